// File: rtl/sys_array_host.sv
// Host-side sequencer for sys_array_fetcher: packs streamed A/B matrices, runs the
// load/start handshake, captures the result matrix and drains it as a stream.
module sys_array_host #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 5,
  parameter int ARRAY_L    = 2,
  parameter int GAP_CYCLES = 6,
  parameter int START_HOLD = 6
) (
  input  logic                                                   clk,
  input  logic                                                   reset_n,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [DATA_WIDTH-1:0]                                  in_data,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [2*DATA_WIDTH-1:0]                                out_elem,
  output logic                                                   out_last,
  output logic                                                   busy,
  output logic                                                   load_params,
  output logic                                                   start_comp,
  output logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]        input_data_a,
  output logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]        input_data_b,
  input  logic                                                   ready,
  input  logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0]      out_data
);

  localparam int EW   = 2 * DATA_WIDTH;
  localparam int NAB  = ARRAY_W * ARRAY_L;
  localparam int NRES = ARRAY_W * ARRAY_W;
  localparam int AW   = (NAB > 1) ? $clog2(NAB) : 1;
  localparam int RW   = (NRES > 1) ? $clog2(NRES) : 1;
  localparam int TMAX = (GAP_CYCLES > START_HOLD) ? GAP_CYCLES : START_HOLD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [AW-1:0] LAST_AB   = AW'(NAB - 1);
  localparam logic [RW-1:0] LAST_RES  = RW'(NRES - 1);
  localparam logic [TW-1:0] LAST_GAP  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] LAST_HOLD = TW'(START_HOLD - 1);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD_A     = 4'd1,
    ST_LOAD_B     = 4'd2,
    ST_LOAD_PULSE = 4'd3,
    ST_GAP        = 4'd4,
    ST_START      = 4'd5,
    ST_WAIT_RDY   = 4'd6,
    ST_CAPTURE    = 4'd7,
    ST_DRAIN      = 4'd8
  } state_t;

  state_t                  state_r, next_s;
  logic [AW-1:0]           ab_cnt_r;
  logic [RW-1:0]           res_cnt_r;
  logic [TW-1:0]           timer_r;
  logic [NAB*DATA_WIDTH-1:0] a_r, b_r;
  logic [NRES*EW-1:0]      buffer_r;
  logic                    in_ready_r, out_valid_r, out_last_r, busy_r, load_params_r, start_comp_r;
  logic                    in_ready_s, out_valid_s, busy_s, load_params_s, start_comp_s;
  logic                    accept_s, drain_hs_s;

  assign accept_s   = in_valid && in_ready_r;
  assign drain_hs_s = out_valid_r && out_ready;

  // Next-state selection
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE:       next_s = ST_LOAD_A;
      ST_LOAD_A:     if (accept_s && (ab_cnt_r == LAST_AB)) next_s = ST_LOAD_B; else next_s = state_r;
      ST_LOAD_B:     if (accept_s && (ab_cnt_r == LAST_AB)) next_s = ST_LOAD_PULSE; else next_s = state_r;
      ST_LOAD_PULSE: next_s = ST_GAP;
      ST_GAP:        if (timer_r == LAST_GAP) next_s = ST_START; else next_s = state_r;
      ST_START:      if (timer_r == LAST_HOLD) next_s = ST_WAIT_RDY; else next_s = state_r;
      ST_WAIT_RDY:   if (ready) next_s = ST_CAPTURE; else next_s = state_r;
      ST_CAPTURE:    next_s = ST_DRAIN;
      ST_DRAIN:      if (drain_hs_s && (res_cnt_r == LAST_RES)) next_s = ST_LOAD_A; else next_s = state_r;
      default:       next_s = ST_IDLE;
    endcase
  end

  // Control outputs decoded from the upcoming state so they can be registered
  always_comb begin
    in_ready_s    = 1'b0;
    out_valid_s   = 1'b0;
    busy_s        = 1'b0;
    load_params_s = 1'b0;
    start_comp_s  = 1'b0;
    case (next_s)
      ST_LOAD_A, ST_LOAD_B:             in_ready_s = 1'b1;
      ST_LOAD_PULSE: begin
        load_params_s = 1'b1;
        busy_s        = 1'b1;
      end
      ST_GAP, ST_WAIT_RDY, ST_CAPTURE:  busy_s = 1'b1;
      ST_START: begin
        start_comp_s = 1'b1;
        busy_s       = 1'b1;
      end
      ST_DRAIN: begin
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default:                          busy_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= next_s;
  end

  // Registered control outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      load_params_r <= 1'b0;
      start_comp_r  <= 1'b0;
    end else begin
      in_ready_r    <= in_ready_s;
      out_valid_r   <= out_valid_s;
      busy_r        <= busy_s;
      load_params_r <= load_params_s;
      start_comp_r  <= start_comp_s;
    end
  end

  // Counters, matrix packing and result buffer; the buffer shifts so its top slot is the live element
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ab_cnt_r   <= '0;
      res_cnt_r  <= '0;
      timer_r    <= '0;
      a_r        <= '0;
      b_r        <= '0;
      buffer_r   <= '0;
      out_last_r <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD_A, ST_LOAD_B: begin
          timer_r <= '0;
          if (accept_s) begin
            if (state_r == ST_LOAD_A) a_r[(NAB - 1 - int'(ab_cnt_r)) * DATA_WIDTH +: DATA_WIDTH] <= in_data;
            else                      b_r[(NAB - 1 - int'(ab_cnt_r)) * DATA_WIDTH +: DATA_WIDTH] <= in_data;
            ab_cnt_r <= (ab_cnt_r == LAST_AB) ? '0 : ab_cnt_r + AW'(1);
          end
        end
        ST_GAP, ST_START: timer_r <= (next_s == state_r) ? timer_r + TW'(1) : '0;
        ST_CAPTURE: begin
          buffer_r   <= out_data;
          res_cnt_r  <= '0;
          out_last_r <= (LAST_RES == '0);
        end
        ST_DRAIN: begin
          if (drain_hs_s) begin
            buffer_r   <= buffer_r << EW;
            res_cnt_r  <= (res_cnt_r == LAST_RES) ? '0 : res_cnt_r + RW'(1);
            out_last_r <= ((res_cnt_r + RW'(1)) == LAST_RES);
          end
        end
        default: begin
          ab_cnt_r   <= '0;
          timer_r    <= '0;
          out_last_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_last     = out_last_r;
  assign busy         = busy_r;
  assign load_params  = load_params_r;
  assign start_comp   = start_comp_r;
  assign out_elem     = buffer_r[NRES*EW-1 -: EW];
  assign input_data_a = a_r;
  assign input_data_b = b_r;

endmodule

// File: tb/tb_sys_array_host.sv
// Bench for sys_array_host: table of directed jobs, reset-mid-drain sequence and
// random jobs, all checked against a fetcher model and matrix/stream reference.
module tb_sys_array_host;
  localparam int W = 5, L = 2, D = 8, NAB = W * L, NRES = W * W, GAP = 6, HOLD = 6;

  logic clk = 1'b0, reset_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last, busy, load_params, start_comp, ready;
  logic [D-1:0] in_data = '0;
  logic [2*D-1:0] out_elem;
  logic [0:W-1][0:L-1][D-1:0] input_data_a, input_data_b;
  logic [0:W-1][0:W-1][2*D-1:0] out_data;

  int errors = 0, checks = 0, edge_cnt = 0;

  sys_array_host #(.DATA_WIDTH(D), .ARRAY_W(W), .ARRAY_L(L), .GAP_CYCLES(GAP), .START_HOLD(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_elem(out_elem), .out_last(out_last),
    .busy(busy), .load_params(load_params), .start_comp(start_comp),
    .input_data_a(input_data_a), .input_data_b(input_data_b), .ready(ready), .out_data(out_data));

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Fetcher model: ready 10 cycles after start_comp falls; data is garbage until then
  logic sc_prev = 1'b0, spur_on = 1'b0;
  bit spurious_mode = 1'b0;
  int low_cnt = 0;
  logic [15:0] res_base = '0;
  always @(negedge clk) begin
    sc_prev <= start_comp;
    if (load_params) begin
      low_cnt <= 0;
      spur_on <= spurious_mode;
    end else if (sc_prev && !start_comp) begin
      low_cnt <= 1;
      spur_on <= 1'b0;
    end else if (low_cnt > 0 && low_cnt < 1000) begin
      low_cnt <= low_cnt + 1;
    end
  end
  assign ready = spur_on || (low_cnt >= 10);
  always_comb begin
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        out_data[i][j] = (low_cnt >= 10) ? 16'(i * 256 + j) + res_base : 16'hDEAD;
  end

  typedef struct {
    string name;
    int a_start, a_step, vmode, rmode;
    bit spur;
    logic [7:0] exp_a00, exp_a41, exp_b00;
    int exp_gap, exp_hold;
  } entry_t;
  entry_t tbl[5];
  logic [7:0] sa[NAB], sb[NAB];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'd0);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_out_elem"}, 128'(out_elem), 128'd0);
    check({tag, "_out_last"}, 128'(out_last), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_load_params"}, 128'(load_params), 128'd0);
    check({tag, "_start_comp"}, 128'(start_comp), 128'd0);
    check({tag, "_mat_a"}, 128'(input_data_a), 128'd0);
    check({tag, "_mat_b"}, 128'(input_data_b), 128'd0);
  endtask

  task automatic set_entry(input int k, input string nm, input int st, input int stp, input int vm, input int rm,
                           input bit sp, input logic [7:0] a00, input logic [7:0] a41, input logic [7:0] b00);
    tbl[k].name = nm; tbl[k].a_start = st; tbl[k].a_step = stp; tbl[k].vmode = vm; tbl[k].rmode = rm;
    tbl[k].spur = sp; tbl[k].exp_a00 = a00; tbl[k].exp_a41 = a41; tbl[k].exp_b00 = b00;
    tbl[k].exp_gap = 7; tbl[k].exp_hold = 6;
  endtask

  task automatic run_job(input int vmode, input int rmode, input bit spur, input int abort_after,
                         input logic [15:0] base, input string tag, output int gap, output int hold);
    int idx, tmo, last_edge, got, lim, lp_edge, lp_cnt, sc_first, sc_cnt, first_v, last_hs, bad_ir;
    bit v, r, prev_stall;
    logic [15:0] prev_elem, ev;
    logic prev_last;
    logic [0:W-1][0:L-1][D-1:0] ea, eb;
    spurious_mode = spur;
    res_base = base;
    for (int n = 0; n < NAB; n++) begin
      ea[n / L][n % L] = sa[n];
      eb[n / L][n % L] = sb[n];
    end
    idx = 0; tmo = 0; last_edge = -1; out_ready = 1'b1;
    while (idx < 2 * NAB && tmo < 1000) begin
      @(negedge clk);
      tmo++;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (tmo % 2) == 1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data = (idx < NAB) ? sa[idx] : sb[idx - NAB];
      if (v && in_ready) begin
        idx++;
        last_edge = edge_cnt + 1;
      end
    end
    check({tag, "_ingest_beats"}, 128'(idx), 128'(2 * NAB));
    lim = (abort_after > 0) ? abort_after : NRES;
    got = 0; tmo = 0; lp_edge = -1; lp_cnt = 0; sc_first = -1; sc_cnt = 0;
    first_v = -1; last_hs = -1; bad_ir = 0; prev_stall = 1'b0; prev_elem = '0; prev_last = 1'b0;
    while (got < lim && tmo < 3000) begin
      @(negedge clk);
      tmo++;
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'hEE;
      if (in_ready) bad_ir++;
      if (load_params) begin
        lp_cnt++;
        if (lp_edge < 0) lp_edge = edge_cnt;
      end
      if (start_comp) begin
        sc_cnt++;
        if (sc_first < 0) sc_first = edge_cnt;
      end
      if (out_valid) begin
        if (first_v < 0) begin
          first_v = edge_cnt;
          check({tag, "_busy_drain"}, 128'(busy), 128'd1);
        end
        ev = 16'((got / W) * 256 + (got % W)) + base;
        if (prev_stall) begin
          check({tag, "_stall_elem"}, 128'(out_elem), 128'(prev_elem));
          check({tag, "_stall_last"}, 128'(out_last), 128'(prev_last));
        end
        check({tag, "_elem"}, 128'(out_elem), 128'(ev));
        check({tag, "_last"}, 128'(out_last), 128'(got == NRES - 1));
        r = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        out_ready = r;
        prev_stall = !r;
        prev_elem = out_elem;
        prev_last = out_last;
        if (r) begin
          got++;
          last_hs = edge_cnt + 1;
        end
      end else begin
        out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        prev_stall = 1'b0;
      end
    end
    in_valid = 1'b0;
    check({tag, "_drain_beats"}, 128'(got), 128'(lim));
    check({tag, "_in_ready_busy"}, 128'(bad_ir), 128'd0);
    check({tag, "_lp_pulses"}, 128'(lp_cnt), 128'd1);
    check({tag, "_lp_edge"}, 128'(lp_edge), 128'(last_edge));
    gap = sc_first - lp_edge;
    hold = sc_cnt;
    if (abort_after == 0) begin
      if (rmode == 0) check({tag, "_drain_cycles"}, 128'(last_hs - first_v), 128'(NRES));
      @(negedge clk);
      check({tag, "_turn_in_ready"}, 128'(in_ready), 128'd1);
      check({tag, "_turn_out_valid"}, 128'(out_valid), 128'd0);
      check({tag, "_turn_busy"}, 128'(busy), 128'd0);
      check({tag, "_mat_a"}, 128'(input_data_a), 128'(ea));
      check({tag, "_mat_b"}, 128'(input_data_b), 128'(eb));
    end
  endtask

  task automatic run_entry(input int k);
    int g, h;
    for (int n = 0; n < NAB; n++) begin
      sa[n] = 8'(tbl[k].a_start + tbl[k].a_step * n);
      sb[n] = sa[n];
    end
    run_job(tbl[k].vmode, tbl[k].rmode, tbl[k].spur, 0, 16'h0000, tbl[k].name, g, h);
    check({tbl[k].name, "_a00"}, 128'(input_data_a[0][0]), 128'(tbl[k].exp_a00));
    check({tbl[k].name, "_a41"}, 128'(input_data_a[4][1]), 128'(tbl[k].exp_a41));
    check({tbl[k].name, "_b00"}, 128'(input_data_b[0][0]), 128'(tbl[k].exp_b00));
    check({tbl[k].name, "_gap"}, 128'(g), 128'(tbl[k].exp_gap));
    check({tbl[k].name, "_hold"}, 128'(h), 128'(tbl[k].exp_hold));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, h;
    set_entry(0, "basic", 1, 1, 0, 0, 1'b0, 8'd1, 8'd10, 8'd1);
    set_entry(1, "stall_in", 1, 1, 1, 0, 1'b0, 8'd1, 8'd10, 8'd1);
    set_entry(2, "backpressure", 1, 1, 0, 1, 1'b0, 8'd1, 8'd10, 8'd1);
    set_entry(3, "spurious_rdy", 1, 1, 0, 0, 1'b1, 8'd1, 8'd10, 8'd1);
    set_entry(4, "back_to_back", 10, -1, 0, 0, 1'b0, 8'd10, 8'd1, 8'd10);

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    #1 check("release_in_ready0", 128'(in_ready), 128'd0);
    @(negedge clk);
    check("release_in_ready1", 128'(in_ready), 128'd1);

    for (int k = 0; k < 5; k++) begin
      if (k > 0) check({tbl[k].name, "_a00_held"}, 128'(input_data_a[0][0]), 128'(tbl[k - 1].exp_a00));
      run_entry(k);
    end

    // Reset in the middle of a drain, then a full clean run
    for (int n = 0; n < NAB; n++) begin
      sa[n] = 8'(n + 1);
      sb[n] = sa[n];
    end
    run_job(0, 0, 1'b0, 7, 16'h0000, "mid_reset", g, h);
    @(negedge clk);
    reset_n = 1'b0;
    #1 check_zero("mid_reset_async");
    repeat (2) @(negedge clk);
    check_zero("mid_reset_held");
    reset_n = 1'b1;
    #1 check("mid_release_in_ready0", 128'(in_ready), 128'd0);
    @(negedge clk);
    check("mid_release_in_ready1", 128'(in_ready), 128'd1);
    run_entry(0);

    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < NAB; n++) begin
        sa[n] = 8'($urandom);
        sb[n] = 8'($urandom);
      end
      run_job($urandom_range(0, 2), $urandom_range(0, 1), 1'($urandom_range(0, 1)), 0,
              16'($urandom), "rand", g, h);
      check("rand_gap", 128'(g), 128'(GAP + 1));
      check("rand_hold", 128'(h), 128'(HOLD));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
